// File: rtl/handshake_broadcast_tx.sv
// Ready/valid broadcaster: holds one upstream word and offers it to four
// downstream ports, retiring it once every port has completed its transfer.
module handshake_broadcast_tx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             handshake_valid,
  input  logic             handshake_ready,
  output logic             handshake_arr_0_valid,
  input  logic             handshake_arr_0_ready,
  output logic             handshake_arr_1_valid,
  input  logic             handshake_arr_1_ready,
  output logic             handshake_arr_2_valid,
  input  logic             handshake_arr_2_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             temp1,
  output logic             temp2,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic {IDLE, BUSY} state_e;

  // Bit 0 is the primary port, bits 1..3 are arr_0..arr_2.
  logic [3:0]       pend, pend_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [3:0]       ready, fire;
  logic             last, acc, retire;
  state_e           state;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      pend   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend   <= pend_nxt;
      data_q <= data_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  // The last outstanding fire frees the slot in the same cycle, so a new
  // word can be accepted on the retire edge without a bubble.
  always_comb begin
    ready    = {handshake_arr_2_ready, handshake_arr_1_ready,
                handshake_arr_0_ready, handshake_ready};
    fire     = pend & ready;
    last     = ((pend & ~fire) == 4'b0000);
    state    = (pend == 4'b0000) ? IDLE : BUSY;
    acc      = in_valid & last;
    retire   = (state == BUSY) & last;
    pend_nxt = acc ? 4'b1111 : (pend & ~fire);
    data_nxt = acc ? in_data : data_q;
    cnt_nxt  = cnt_q + CNT_W'(retire);
  end

  always_comb begin
    handshake_valid       = pend[0];
    handshake_arr_0_valid = pend[1];
    handshake_arr_1_valid = pend[2];
    handshake_arr_2_valid = pend[3];
    in_ready              = last;
    out_data              = data_q;
    temp1                 = |data_q;
    temp2                 = &data_q;
    retired_cnt           = cnt_q;
  end

endmodule

// File: doc/handshake_broadcast_tx.md
# handshake_broadcast_tx

Transmit-side ready/valid broadcaster. It accepts one payload word on an upstream handshake and presents it on a single downstream `handshake` port plus three `handshake_arr` ports. Each downstream port completes its own transfer independently, and the word retires only after every port has taken it. It is the driving end of the `handshake` / `handshake_arr_*` interfaces and feeds the blocks those interfaces connect to. It also publishes the reduction flags (OR and AND of the held word) that the downstream checker correlates with `out`.

## Interface
Parameters:
- `WIDTH`, 4: payload width in bits.
- `CNT_W`, 8: width of the retired-word counter.

Ports:
- `CLK`  input  1: single clock; all state updates on the rising edge.
- `RESETN`  input  1: synchronous, active-low reset, sampled on the rising edge of `CLK`.
- `in_valid`  input  1: upstream payload valid.
- `in_ready`  output  1: upstream ready.
- `in_data`  input  WIDTH: upstream payload.
- `handshake_valid`  output  1: primary downstream valid.
- `handshake_ready`  input  1: primary downstream ready.
- `handshake_arr_0_valid`, `handshake_arr_1_valid`, `handshake_arr_2_valid`  output  1 each: array downstream valids.
- `handshake_arr_0_ready`, `handshake_arr_1_ready`, `handshake_arr_2_ready`  input  1 each: array downstream readies.
- `out_data`  output  WIDTH: held payload, shared by all four downstream ports.
- `temp1`  output  1: `|out_data`.
- `temp2`  output  1: `&out_data`.
- `retired_cnt`  output  CNT_W: number of words retired since reset.

## Operation
- State:
  - `pend[3:0]` (bit 0 = primary, bits 1..3 = arr_0..arr_2)
  - `out_data`
  - `retired_cnt`
- States are derived from `pend`:
  - IDLE: `pend == 0`.
  - BUSY: `pend != 0`.
- Each downstream valid equals its `pend` bit.
- Port fire: `fire[i] = pend[i] & ready[i]`.
- `last = (pend & ~fire) == 0`, i.e. every outstanding port fires this cycle or nothing is pending.
- `in_ready = last`. This is combinational on the downstream readies, so back-to-back words are possible.
- Upstream accept: `acc = in_valid & in_ready`.
- On `acc`:
  - `out_data <= in_data`.
  - `pend <= 4'b1111`.
- Otherwise: `pend <= pend & ~fire`.
- A word retires when `pend != 0` and `last`. On retire, `retired_cnt` increments by 1 and wraps modulo 2^CNT_W with no saturation.
- `out_data` is stable while BUSY. It changes only on `acc`.
- `temp1` and `temp2` are combinational from `out_data`, so they are valid whenever any valid is high.
- No valid may drop without its ready. This holds by construction because a `pend` bit clears only on `fire`.
- Downstream readies may be high while the corresponding valid is low. Such readies have no effect.

## Timing
- Reset: when `RESETN == 0` at the clock edge, the following apply on the next cycle:
  - `pend = 0`, so all four valids are 0.
  - `out_data = 0`, so `temp1 = 0` and `temp2 = 0`.
  - `retired_cnt = 0`.
  - `in_ready` evaluates to 1.
- Reset mid-transfer abandons the held word without counting it.
- During reset, `in_ready` may read 1, but no accept is taken.
- Latency: the word accepted at edge N shows valid on all ports in cycle N+1.
- Minimum occupancy is 1 cycle.
- Throughput is 1 word/cycle when all readies are held high.
- A single slow port stalls upstream. The other ports do not re-see the word after they fire.
- Simultaneous last fire and new `in_valid`: the retire, the counter increment and the new accept all happen on the same edge, with no bubble.
- Readies arriving in different cycles: each valid deasserts the cycle after its own fire.

## Test plan
- Reset: hold `RESETN = 0` for 2 cycles with `in_valid = 1` -> all valids 0, `out_data = 0`, `retired_cnt = 0`, no accept; release reset -> the word is accepted on the first active edge.
- Single word: `in_data = 4'hF`, all readies 1 -> one cycle later all four valids = 1, `temp1 = 1`, `temp2 = 1`; the next cycle all valids drop; `retired_cnt = 1`.
- Staggered readies: word `4'h5`; fire primary in cycle 1, arr_0 in cycle 2, arr_2 in cycle 3, arr_1 in cycle 5 -> each valid drops the cycle after its fire; `in_ready = 0` until cycle 5; `out_data` holds 5 throughout; `temp1 = 1`, `temp2 = 0`.
- Back-to-back streaming: words 1, 2, 3, 4, all readies 1 continuously -> one word per cycle on every port, in order; `retired_cnt = 4`.
- Last fire coincident with new word: arr_1 is the only pending port and fires while `in_valid = 1` with `in_data = 4'h0` -> same edge: `pend = 4'b1111`, `out_data = 0`, `temp1 = 0`, and `retired_cnt` increments.
- Counter wrap: retire 256 words with `CNT_W = 8` -> `retired_cnt` returns to 0; assert that a valid never falls without its ready across the full run.
